// File: rtl/sonar_pkg.sv
// Shared types and timing constants for the ultrasonic ranging path.
// Used by the echo timer and the downstream distance stage.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } sonar_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned TRIG_CYCLES_DEF = 500;
  localparam int unsigned PERIOD_CYCLES_DEF = 3_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_900_000;
  localparam int unsigned CNT_W_DEF = 32;

  // Round-trip echo cycles per centimetre at 343 m/s.
  localparam int unsigned CYC_PER_CM = 2915;

endpackage

// File: rtl/sonar_sync_edge.sv
// Two-flop synchronizer for the raw echo pin.
// A third flop yields single-cycle rise/fall pulses.
module sonar_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] synchronize; [2] is the delayed copy for edges
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  // shift the pin in one stage per clock
  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  // register the shift chain, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/sonar_echo_timer.sv
// Ultrasonic sensor front-end: periodic trigger and echo timing.
// Reports echo width with valid, or a timeout strobe.
module sonar_echo_timer
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             echo,
  output logic             trigger,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic echo_hi;
  logic echo_rise;
  logic echo_fall;

  sonar_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (echo),
    .level(echo_hi),
    .rise (echo_rise),
    .fall (echo_fall)
  );

  sonar_state_t     state_q, state_d;
  logic             trigger_q, trigger_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] wid_q, wid_d;

  // next-state and counter logic for the measurement cycle
  always_comb begin
    state_d       = state_q;
    trigger_d     = trigger_q;
    valid_d       = 1'b0;
    timeout_d     = 1'b0;
    echo_cycles_d = echo_cycles_q;
    to_d          = to_q;
    wid_d         = wid_q;
    // period counter saturates so it can never wrap
    per_d = (per_q < PER_LAST) ? per_q + 1'b1 : per_q;

    unique case (state_q)
      IDLE: begin
        per_d = '0;
        if (enable) begin
          state_d   = TRIG;
          trigger_d = 1'b1;
        end
      end
      TRIG: begin
        if (per_q == TRIG_LAST) begin
          state_d   = WAIT_RISE;
          trigger_d = 1'b0;
          to_d      = '0;
        end
      end
      WAIT_RISE: begin
        to_d = to_q + 1'b1;
        if (to_q >= TO_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else if (echo_rise) begin
          state_d = MEASURE;
          wid_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        // a fall in the expiry cycle still counts as a result
        if (echo_fall) begin
          state_d       = HOLDOFF;
          valid_d       = 1'b1;
          echo_cycles_d = wid_q;
        end else if (to_q >= TO_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (echo_hi) begin
            wid_d = wid_q + 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (per_q >= PER_LAST) begin
          per_d = '0;
          if (enable) begin
            state_d   = TRIG;
            trigger_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        trigger_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      trigger_q     <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      echo_cycles_q <= '0;
      per_q         <= '0;
      to_q          <= '0;
      wid_q         <= '0;
    end else begin
      state_q       <= state_d;
      trigger_q     <= trigger_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      echo_cycles_q <= echo_cycles_d;
      per_q         <= per_d;
      to_q          <= to_d;
      wid_q         <= wid_d;
    end
  end

  assign trigger     = trigger_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;
  assign echo_cycles = echo_cycles_q;

endmodule

// File: tb/tb_sonar_echo_timer.sv
// Directed bench for sonar_echo_timer.
// Small trigger/period/timeout values keep the run short.
module tb_sonar_echo_timer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        echo;
  logic        trigger;
  logic [31:0] echo_cycles;
  logic        valid;
  logic        timeout;
  logic        busy;

  int total;
  int bad;
  int cyc;
  int t_rise;
  int t_fall;

  sonar_echo_timer #(
    .TRIG_CYCLES   (500),
    .PERIOD_CYCLES (2000),
    .TIMEOUT_CYCLES(1000),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .echo       (echo),
    .trigger    (trigger),
    .echo_cycles(echo_cycles),
    .valid      (valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_trig(input logic lvl, input int lim,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (trigger === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int lim, output int n,
                           output logic v, output logic t);
    n = 0;
    v = 1'b0;
    t = 1'b0;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || timeout === 1'b1) begin
        n = i;
        v = valid;
        t = timeout;
        break;
      end
    end
  endtask

  // next trigger rise, spacing checked against previous rise
  task automatic next_trigger(input string nm, input bit chk);
    bit ok;
    wait_trig(1'b1, 4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_rise got=none want=rise", nm);
    end else if (chk && (cyc - t_rise) != 2000) begin
      bad++;
      $display("FAIL %s_spacing got=%0d want=2000", nm, cyc - t_rise);
    end
    t_rise = cyc;
    wait_trig(1'b0, 1000, ok);
    total++;
    if (!ok || (cyc - t_rise) != 500) begin
      bad++;
      $display("FAIL %s_trig_width got=%0d want=500", nm, cyc - t_rise);
    end
    t_fall = cyc;
  endtask

  task automatic pulse_echo(input int dly, input int w);
    repeat (dly) @(posedge clk);
    #1 echo = 1'b1;
    repeat (w) @(posedge clk);
    #1 echo = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    #12;
    total++;
    if ({trigger, valid, timeout, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {trigger, valid, timeout, busy});
    end
    total++;
    if (echo_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_echo_cycles got=%0d want=0", echo_cycles);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || trigger !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold got=%b%b want=00", busy, trigger);
    end
  endtask

  task automatic test_basic;
    int n;
    logic v, t;
    enable = 1'b1;
    next_trigger("basic", 1'b0);
    pulse_echo(10, 25);
    wait_done(10, n, v, t);
    total++;
    if (n != 3 || v !== 1'b1 || t !== 1'b0) begin
      bad++;
      $display("FAIL basic_valid got=n%0d v%b t%b want=n3 v1 t0",
               n, v, t);
    end
    total++;
    if (echo_cycles !== 32'd25) begin
      bad++;
      $display("FAIL basic_width got=%0d want=25", echo_cycles);
    end
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_pulse got=v%b b%b want=v0 b1", valid, busy);
    end
  endtask

  task automatic test_no_echo;
    int n;
    logic v, t;
    echo = 1'b0;
    next_trigger("noecho", 1'b1);
    wait_done(1500, n, v, t);
    total++;
    if (n != 1000 || t !== 1'b1 || v !== 1'b0) begin
      bad++;
      $display("FAIL noecho_timeout got=n%0d t%b v%b want=n1000 t1 v0",
               n, t, v);
    end
    total++;
    if (echo_cycles !== 32'd25) begin
      bad++;
      $display("FAIL noecho_hold got=%0d want=25", echo_cycles);
    end
  endtask

  task automatic test_stuck_high;
    int n;
    logic v, t;
    echo = 1'b1;
    next_trigger("stuck", 1'b1);
    wait_done(1500, n, v, t);
    total++;
    if (n != 1000 || t !== 1'b1 || v !== 1'b0) begin
      bad++;
      $display("FAIL stuck_timeout got=n%0d t%b v%b want=n1000 t1 v0",
               n, t, v);
    end
    echo = 1'b0;
  endtask

  task automatic test_back_to_back;
    int widths[2] = '{7, 300};
    int n;
    logic v, t;
    foreach (widths[k]) begin
      next_trigger("b2b", 1'b1);
      pulse_echo(10, widths[k]);
      wait_done(10, n, v, t);
      total++;
      if (n != 3 || v !== 1'b1 || echo_cycles !== 32'(widths[k])) begin
        bad++;
        $display("FAIL b2b_width got=n%0d v%b w%0d want=n3 v1 w%0d",
                 n, v, echo_cycles, widths[k]);
      end
    end
  endtask

  task automatic test_coincide;
    int n;
    logic v, t;
    // fall registers on the same edge the timeout would
    next_trigger("coin", 1'b1);
    pulse_echo(10, 987);
    wait_done(10, n, v, t);
    total++;
    if (v !== 1'b1 || t !== 1'b0 || (cyc - t_fall) != 1000) begin
      bad++;
      $display("FAIL coin_fall_wins got=v%b t%b at%0d want=v1 t0 at1000",
               v, t, cyc - t_fall);
    end
    total++;
    if (echo_cycles !== 32'd987) begin
      bad++;
      $display("FAIL coin_width got=%0d want=987", echo_cycles);
    end
    @(posedge clk);
    #1;
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL coin_no_late_timeout got=%b want=0", timeout);
    end
    // one cycle longer: timeout fires first
    next_trigger("late", 1'b1);
    repeat (10) @(posedge clk);
    #1 echo = 1'b1;
    wait_done(1200, n, v, t);
    total++;
    if (t !== 1'b1 || v !== 1'b0 || (cyc - t_fall) != 1000) begin
      bad++;
      $display("FAIL late_timeout got=t%b v%b at%0d want=t1 v0 at1000",
               t, v, cyc - t_fall);
    end
    total++;
    if (echo_cycles !== 32'd987) begin
      bad++;
      $display("FAIL late_hold got=%0d want=987", echo_cycles);
    end
    echo = 1'b0;
  endtask

  task automatic test_reset_mid;
    next_trigger("rstmid", 1'b1);
    pulse_echo(10, 0);
    #1 echo = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy_before got=%b want=1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({trigger, busy, valid, timeout} !== 4'b0 ||
        echo_cycles !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_async got=%b w%0d want=0000 w0",
               {trigger, busy, valid, timeout}, echo_cycles);
    end
    echo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable_drop;
    int n;
    int trig_seen;
    logic v, t;
    next_trigger("endrop", 1'b0);
    repeat (10) @(posedge clk);
    #1 echo = 1'b1;
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1 echo = 1'b0;
    wait_done(10, n, v, t);
    total++;
    if (n != 3 || v !== 1'b1 || echo_cycles !== 32'd40) begin
      bad++;
      $display("FAIL endrop_valid got=n%0d v%b w%0d want=n3 v1 w40",
               n, v, echo_cycles);
    end
    trig_seen = 0;
    repeat (2500) begin
      @(posedge clk);
      #1;
      if (trigger === 1'b1) trig_seen++;
    end
    total++;
    if (trig_seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL endrop_idle got=trig%0d busy%b want=trig0 busy0",
               trig_seen, busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    t_rise = 0;
    t_fall = 0;
    test_reset;
    test_basic;
    test_no_echo;
    test_stuck_high;
    test_back_to_back;
    test_coincide;
    test_reset_mid;
    test_enable_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonar_echo_timer.md
Name: sonar_echo_timer

Overview:
- Upstream front-end for the ultrasonic ranging path. Drives the sensor trigger pulse and times the sensor echo pulse in clock cycles.
- Presents the echo width with a one-cycle valid strobe to the downstream distance-conversion stage (DOUBLE_MUL), which consumes trigger/echo-derived timing and produces the 32-bit distance.
- Free-runs at a fixed measurement period while enabled; reports a timeout when no echo arrives.

Parameters:
- TRIG_CYCLES, 500: trigger high width in clk cycles (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: trigger-start to trigger-start spacing (60 ms).
- TIMEOUT_CYCLES, 1900000: maximum cycles from trigger fall to echo fall before abort (38 ms).
- CNT_W, 32: counter and echo_cycles width; must satisfy PERIOD_CYCLES < 2^CNT_W.

Ports:
- clk, input, 1: single system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: run periodic measurements while high.
- echo, input, 1: raw sensor echo, asynchronous to clk.
- trigger, output, 1: sensor trigger pulse, registered.
- echo_cycles, output, CNT_W: last measured echo high width in cycles.
- valid, output, 1: one-cycle strobe, echo_cycles updated this cycle.
- timeout, output, 1: one-cycle strobe, measurement aborted.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async, any state): trigger=0, echo_cycles=0, valid=0, timeout=0, busy=0, state=IDLE, all counters=0, synchronizer flops=0.
- echo passes through a 2-flop synchronizer. rise/fall are single-cycle pulses from comparing the 2nd flop with a 3rd delayed flop.
- IDLE:
  - If enable=1, go to TRIG next cycle with trigger=1 and period counter cleared to 0.
  - If enable=0, remain in IDLE.
- TRIG:
  - trigger is high for exactly TRIG_CYCLES cycles.
  - Then go to WAIT_RISE with trigger=0 and the timeout counter cleared.
  - Echo edges in this state are ignored.
- WAIT_RISE:
  - Proceed only on a rise pulse: go to MEASURE with width counter=1.
  - If echo is already high when TRIG ends, no rise is produced. The block waits for a genuine edge, so a stuck-high echo ends in timeout.
- MEASURE:
  - The width counter increments each cycle the synchronized echo is high.
  - On fall: echo_cycles<=width counter, valid=1 for one cycle, go to HOLDOFF.
- Timeout counter:
  - Runs through WAIT_RISE and MEASURE.
  - On reaching TIMEOUT_CYCLES: timeout=1 for one cycle, echo_cycles unchanged, go to HOLDOFF.
  - If fall and timeout expiry coincide, fall wins: valid only, no timeout.
- HOLDOFF:
  - The period counter keeps running from trigger start.
  - When it reaches PERIOD_CYCLES-1: go to TRIG if enable=1, else IDLE.
  - Minimum re-trigger spacing is always PERIOD_CYCLES.
- Width convention: an echo pin high for N whole cycles yields echo_cycles=N.
- Latency: valid asserts on the 3rd rising clk edge after the first edge that samples echo low.
- enable deassert mid-measurement: the current cycle completes (valid or timeout delivered), then the block settles in IDLE. No truncated trigger pulse is ever produced.
- Counters never wrap: PERIOD_CYCLES bounds all counts.
- valid and timeout are never high together.
- echo_cycles holds its value until the next valid.

Decomposition:
- Package sonar_pkg: state enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF) and default timing constants shared with the distance stage (CLK_HZ=50000000, cycles per cm for the downstream multiplier).
- Sub-module sonar_sync_edge: 2-flop synchronizer plus rise/fall pulse generator, reset to 0.
- FSM and counters stay in the top module.

Test Plan:
- Basic measurement:
  - Stimulus: reset 1.2 cycles, enable=1; echo high 25 cycles starting 10 cycles after trigger falls.
  - Required: trigger high exactly 500 cycles; echo_cycles=25, valid single pulse 3 cycles after echo falls; timeout=0.
- No echo:
  - Stimulus: TIMEOUT_CYCLES=1000 (sim override), echo held 0.
  - Required: timeout pulse exactly 1000 cycles after trigger falls; echo_cycles keeps its prior value; next trigger at PERIOD_CYCLES from the previous trigger start.
- Stuck-high echo:
  - Stimulus: echo held 1 from before trigger.
  - Required: no valid; timeout after TIMEOUT_CYCLES.
- Back-to-back periodic measurements:
  - Stimulus: PERIOD_CYCLES=2000; echo widths 7 then 300.
  - Required: trigger rising edges 2000 cycles apart; valid with echo_cycles=7, then 300.
- Reset and enable drop mid-operation:
  - Stimulus: assert rst mid-MEASURE.
  - Required: trigger/busy/valid=0 immediately (asynchronously), echo_cycles=0.
  - Stimulus: drop enable mid-MEASURE with echo width 40.
  - Required: valid with echo_cycles=40 delivered, then IDLE, no further trigger.
- Fall coinciding with timeout:
  - Stimulus: echo falls so its fall pulse coincides with the timeout expiry cycle.
  - Required: valid=1, timeout=0.
